// File: rtl/spi_mem_arbiter_if.sv
// Bundle of requester-side (IF/DM) and spi_master-side signals for spi_mem_arbiter.
// Suffixes are from the arbiter's point of view; slave is the arbiter, master is its environment.
interface spi_mem_arbiter_if;
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic [1:0]  if_nbytes_i;
  logic        if_gnt_o;
  logic        if_done_o;
  logic        dm_req_i;
  logic [15:0] dm_addr_i;
  logic [7:0]  dm_wdata_i;
  logic        dm_rnw_i;
  logic [1:0]  dm_nbytes_i;
  logic        dm_gnt_o;
  logic        dm_done_o;
  logic [15:0] rdata_o;
  logic        err_o;
  logic        spi_start_o;
  logic [15:0] spi_address_o;
  logic [7:0]  spi_data_write_o;
  logic        spi_read_not_write_o;
  logic [1:0]  spi_num_bytes_o;
  logic        spi_done_i;
  logic        spi_busy_i;
  logic [7:0]  spi_data_read_byte1_i;
  logic [7:0]  spi_data_read_byte2_i;

  modport master (
    output if_req_i, if_addr_i, if_nbytes_i, dm_req_i, dm_addr_i, dm_wdata_i, dm_rnw_i,
           dm_nbytes_i, spi_done_i, spi_busy_i, spi_data_read_byte1_i, spi_data_read_byte2_i,
    input  if_gnt_o, if_done_o, dm_gnt_o, dm_done_o, rdata_o, err_o, spi_start_o,
           spi_address_o, spi_data_write_o, spi_read_not_write_o, spi_num_bytes_o
  );

  modport slave (
    input  if_req_i, if_addr_i, if_nbytes_i, dm_req_i, dm_addr_i, dm_wdata_i, dm_rnw_i,
           dm_nbytes_i, spi_done_i, spi_busy_i, spi_data_read_byte1_i, spi_data_read_byte2_i,
    output if_gnt_o, if_done_o, dm_gnt_o, dm_done_o, rdata_o, err_o, spi_start_o,
           spi_address_o, spi_data_write_o, spi_read_not_write_o, spi_num_bytes_o
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI master between instruction fetch (IF) and data (DM) ports.
// One SPI transaction per grant; illegal byte counts and timeouts complete with err_o set.
module spi_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic              clk_core_i,
  input logic              rst_i,
  spi_mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rnw_q, rnw_d;
  logic [1:0]       nbytes_q, nbytes_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic             if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;

  logic       sel_dm;
  logic [1:0] sel_nbytes;
  logic       sel_legal;

  // On a tie the port that did not own the previous transaction wins.
  always_comb begin
    sel_dm     = bus.dm_req_i && (!bus.if_req_i || last_owner_q == OWN_IF);
    sel_nbytes = sel_dm ? bus.dm_nbytes_i : bus.if_nbytes_i;
    sel_legal  = (sel_nbytes == 2'd1) || (sel_nbytes == 2'd2);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rnw_d        = rnw_q;
    nbytes_d     = nbytes_q;
    cnt_d        = cnt_q;
    if_gnt_d     = 1'b0;
    dm_gnt_d     = 1'b0;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    err_d        = err_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        // While an illegal-request grant is visible its requester still holds req high.
        if (!bus.spi_busy_i && !if_gnt_q && !dm_gnt_q && (bus.if_req_i || bus.dm_req_i)) begin
          owner_d  = sel_dm;
          addr_d   = sel_dm ? bus.dm_addr_i : bus.if_addr_i;
          wdata_d  = sel_dm ? bus.dm_wdata_i : 8'h00;
          rnw_d    = sel_dm ? bus.dm_rnw_i : 1'b1;
          nbytes_d = sel_nbytes;
          if_gnt_d = !sel_dm;
          dm_gnt_d = sel_dm;
          if (sel_legal) begin
            state_d = ISSUE;
          end else begin
            if_done_d    = !sel_dm;
            dm_done_d    = sel_dm;
            err_d        = 1'b1;
            rdata_d      = 16'h0000;
            last_owner_d = sel_dm;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (bus.spi_done_i || cnt_q == CNT_LAST) begin
          if_done_d    = owner_q == OWN_IF;
          dm_done_d    = owner_q == OWN_DM;
          err_d        = !bus.spi_done_i;
          last_owner_d = owner_q;
          state_d      = IDLE;
          if (!bus.spi_done_i || !rnw_q) begin
            rdata_d = 16'h0000;
          end else if (nbytes_q == 2'd1) begin
            rdata_d = {8'h00, bus.spi_data_read_byte1_i};
          end else begin
            rdata_d = {bus.spi_data_read_byte2_i, bus.spi_data_read_byte1_i};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_DM;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rnw_q        <= 1'b0;
      nbytes_q     <= 2'd0;
      cnt_q        <= '0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rnw_q        <= rnw_d;
      nbytes_q     <= nbytes_d;
      cnt_q        <= cnt_d;
      if_gnt_q     <= if_gnt_d;
      dm_gnt_q     <= dm_gnt_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.if_gnt_o             = if_gnt_q;
  assign bus.dm_gnt_o             = dm_gnt_q;
  assign bus.if_done_o            = if_done_q;
  assign bus.dm_done_o            = dm_done_q;
  assign bus.err_o                = err_q;
  assign bus.rdata_o              = rdata_q;
  assign bus.spi_start_o          = state_q == ISSUE;
  assign bus.spi_address_o        = addr_q;
  assign bus.spi_data_write_o     = wdata_q;
  assign bus.spi_read_not_write_o = rnw_q;
  assign bus.spi_num_bytes_o      = nbytes_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed and randomized bench for spi_mem_arbiter against a transaction-level reference model.
module tb_spi_mem_arbiter;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_arbiter_if bus ();

  spi_mem_arbiter #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (5)
  ) dut (
    .clk_core_i(clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, their fields, arbitration history, held response.
  logic        pend_if, pend_dm, last_dm, prev_illegal, last_err;
  logic [15:0] last_rdata, m_if_addr, m_dm_addr;
  logic [1:0]  m_if_nb, m_dm_nb;
  logic [7:0]  m_dm_wdata;
  logic        m_dm_rnw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({bus.if_gnt_o, bus.if_done_o, bus.dm_gnt_o, bus.dm_done_o, bus.err_o,
                  bus.spi_start_o, bus.spi_read_not_write_o, bus.spi_num_bytes_o,
                  bus.spi_data_write_o}), 32'(0));
    chk({tag, "_data"}, {bus.rdata_o, bus.spi_address_o}, 32'(0));
  endtask

  task automatic raise_if(input logic [15:0] a, input logic [1:0] nb);
    bus.if_req_i = 1'b1; bus.if_addr_i = a; bus.if_nbytes_i = nb;
    m_if_addr = a; m_if_nb = nb; pend_if = 1'b1;
  endtask

  task automatic raise_dm(input logic [15:0] a, input logic [7:0] wd, input logic rnw,
                          input logic [1:0] nb);
    bus.dm_req_i = 1'b1; bus.dm_addr_i = a; bus.dm_wdata_i = wd; bus.dm_rnw_i = rnw;
    bus.dm_nbytes_i = nb;
    m_dm_addr = a; m_dm_wdata = wd; m_dm_rnw = rnw; m_dm_nb = nb; pend_dm = 1'b1;
  endtask

  task automatic drop(input logic d);
    if (d) begin
      bus.dm_req_i = 1'b0; pend_dm = 1'b0;
    end else begin
      bus.if_req_i = 1'b0; pend_if = 1'b0;
    end
  endtask

  task automatic busy_hold(input int n);
    bus.spi_busy_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("busy_no_grant", 32'({bus.if_gnt_o, bus.dm_gnt_o, bus.spi_start_o}), 32'(0));
    end
    bus.spi_busy_i = 1'b0;
  endtask

  // One arbitration round: grant, then either illegal completion or SPI wait of lat cycles.
  task automatic serve(input int lat, input logic [7:0] b1, input logic [7:0] b2,
                       output logic own_o);
    logic        own_dm, legal, seen, fin, tmo;
    logic [15:0] ea, erd;
    logic [7:0]  ew;
    logic        er;
    logic [1:0]  en;
    int          limit;
    own_dm = (pend_if && pend_dm) ? !last_dm : pend_dm;
    own_o  = own_dm;
    ea     = own_dm ? m_dm_addr : m_if_addr;
    ew     = own_dm ? m_dm_wdata : 8'h00;
    er     = own_dm ? m_dm_rnw : 1'b1;
    en     = own_dm ? m_dm_nb : m_if_nb;
    legal  = (en == 2'd1) || (en == 2'd2);
    limit  = prev_illegal ? 2 : 1;
    seen   = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = bus.if_gnt_o | bus.dm_gnt_o;
    end
    chk("gnt_seen", 32'(seen), 32'(1));
    chk("gnt_owner", 32'({bus.dm_gnt_o, bus.if_gnt_o}), own_dm ? 32'(2) : 32'(1));
    chk("start_with_gnt", 32'(bus.spi_start_o), 32'(legal));
    prev_illegal = !legal;
    if (!legal) begin
      chk("bad_done", 32'({bus.dm_done_o, bus.if_done_o}), own_dm ? 32'(2) : 32'(1));
      chk("bad_err_rdata", 32'({bus.err_o, bus.rdata_o}), 32'({1'b1, 16'h0000}));
      last_err = 1'b1; last_rdata = 16'h0000; last_dm = own_dm;
      step();
      drop(own_dm);
      chk("bad_no_start", 32'(bus.spi_start_o), 32'(0));
    end else begin
      chk("spi_fields", 32'({bus.spi_address_o, bus.spi_data_write_o, bus.spi_read_not_write_o,
                             bus.spi_num_bytes_o}), 32'({ea, ew, er, en}));
      step();
      drop(own_dm);
      bus.spi_busy_i = 1'b1;
      fin = 1'b0;
      for (int k = 0; k <= T && !fin; k++) begin
        if (k == lat) begin
          bus.spi_done_i = 1'b1;
          bus.spi_data_read_byte1_i = b1;
          bus.spi_data_read_byte2_i = b2;
        end
        step();
        bus.spi_done_i = 1'b0;
        if (k == lat || k == T - 1) begin
          fin = 1'b1;
          tmo = (k != lat);
          erd = (tmo || !er) ? 16'h0000 : (en == 2'd1) ? {8'h00, b1} : {b2, b1};
          chk("done_owner", 32'({bus.dm_done_o, bus.if_done_o}), own_dm ? 32'(2) : 32'(1));
          chk("done_err_rdata", 32'({bus.err_o, bus.rdata_o}), 32'({tmo, erd}));
          chk("done_spi_held", 32'({bus.spi_address_o, bus.spi_data_write_o,
                                    bus.spi_read_not_write_o, bus.spi_num_bytes_o}),
              32'({ea, ew, er, en}));
          last_err = tmo; last_rdata = erd; last_dm = own_dm;
        end else begin
          chk("wait_quiet", 32'({bus.dm_gnt_o, bus.if_gnt_o, bus.dm_done_o, bus.if_done_o,
                                 bus.spi_start_o}), 32'(0));
          chk("wait_hold", 32'({bus.err_o, bus.rdata_o}), 32'({last_err, last_rdata}));
          chk("wait_spi_stable", 32'({bus.spi_address_o, bus.spi_data_write_o,
                                      bus.spi_read_not_write_o, bus.spi_num_bytes_o}),
              32'({ea, ew, er, en}));
        end
      end
      chk("done_reached", 32'(fin), 32'(1));
      bus.spi_busy_i = 1'b0;
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return r;
    if (r == 6) return T - 2;
    if (r == 7) return T - 1;
    if (r == 8) return T;
    return 999;
  endfunction

  function automatic logic [1:0] pick_nb();
    if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
    return ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic o;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_nbytes_i = 0;
    bus.dm_req_i = 0; bus.dm_addr_i = 0; bus.dm_wdata_i = 0; bus.dm_rnw_i = 0;
    bus.dm_nbytes_i = 0; bus.spi_done_i = 0; bus.spi_busy_i = 0;
    bus.spi_data_read_byte1_i = 0; bus.spi_data_read_byte2_i = 0;
    pend_if = 0; pend_dm = 0; last_dm = 1; prev_illegal = 0; last_err = 0; last_rdata = 0;

    rst = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;

    // IF 2-byte read
    raise_if(16'h0010, 2'd2);
    serve(3, 8'hA5, 8'h3C, o);
    chk("if_read_rdata", 32'(bus.rdata_o), 32'h3CA5);

    // Both requesting continuously, with busy gating first
    raise_if(16'h0100, 2'd1);
    raise_dm(16'h0200, 8'h11, 1'b1, 2'd2);
    busy_hold(2);
    for (int i = 0; i < 4; i++) begin
      serve(i, 8'(8'h20 + i), 8'(8'h40 + i), o);
      if (o) raise_dm(16'h0200, 8'h11, 1'b1, 2'd2);
      else raise_if(16'h0100, 2'd1);
    end
    serve(0, 8'h01, 8'h02, o);
    serve(1, 8'h03, 8'h04, o);

    // DM write, 1 byte
    raise_dm(16'h8001, 8'h7E, 1'b0, 2'd1);
    serve(2, 8'hFF, 8'hEE, o);

    // DM illegal byte count
    raise_dm(16'h1234, 8'h00, 1'b1, 2'd0);
    serve(0, 8'h00, 8'h00, o);

    // Timeout, then a normal request
    raise_if(16'h0042, 2'd2);
    serve(999, 8'h00, 8'h00, o);
    raise_dm(16'h0043, 8'h00, 1'b1, 2'd2);
    serve(1, 8'h5A, 8'hC3, o);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      if (!pend_if && $urandom_range(0, 1) == 1) raise_if(16'($urandom), pick_nb());
      if (!pend_dm && $urandom_range(0, 1) == 1)
        raise_dm(16'($urandom), 8'($urandom), 1'($urandom), pick_nb());
      if (!pend_if && !pend_dm) raise_if(16'($urandom), pick_nb());
      if ($urandom_range(0, 3) == 0) busy_hold(int'($urandom_range(1, 2)));
      serve(pick_lat(), 8'($urandom), 8'($urandom), o);
    end
    while (pend_if || pend_dm) serve(0, 8'($urandom), 8'($urandom), o);

    // Reset during WAIT_DONE
    raise_dm(16'h0777, 8'h00, 1'b1, 2'd2);
    step();
    step();
    rst = 1'b1;
    drop(1'b1);
    step();
    chk_zero("rst_mid");
    bus.spi_done_i = 1'b1;
    step();
    bus.spi_done_i = 1'b0;
    rst = 1'b0;
    chk_zero("rst_hold");
    step();
    chk_zero("rst_no_done");
    last_dm = 1'b1; prev_illegal = 1'b0; last_err = 1'b0; last_rdata = 16'h0000;
    raise_if(16'h0900, 2'd1);
    raise_dm(16'h0A00, 8'h00, 1'b1, 2'd1);
    serve(0, 8'h99, 8'h88, o);
    chk("post_reset_if_first", 32'(o), 32'(0));
    serve(0, 8'h77, 8'h66, o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
